// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared definitions for the execution trace capture buffer:
//            FSM state encoding, trigger mode constants and the packed
//            entry-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

  // Encoding of the capture FSM as seen on o_state.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_POST  = ST_POST,
    S_DONE  = ST_DONE
  } state_t;

  // Trigger source selection (i_trig_mode).
  localparam logic TRIG_OP = 1'b0;
  localparam logic TRIG_PC = 1'b1;

  // Width of one packed ring entry {pc, opcode, reg1, reg2, result}.
  function automatic int entry_w(input int pc_w, input int op_w, input int data_w);
    return pc_w + op_w + 3 * data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
// Module   : trace_ram
// Purpose  : DEPTH x WIDTH storage for the trace ring. One synchronous write
//            port, one asynchronous (combinational) read port. Contents are
//            not reset.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_waddr  - write address
//            i_wdata  - write data
//            i_raddr  - read address
//            o_rdata  - read data (combinational from i_raddr)
// Revision : 1.0 - initial release
// ============================================================================
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture_buffer
// Purpose  : Execution trace recorder. Retired instructions are written into
//            a circular buffer while armed; on an opcode or PC trigger a
//            further POST_TRIG entries are captured, then the window freezes
//            and is drained oldest-first over a valid/ready port.
// Ports    : clk, rst_n            - clock, synchronous active-low reset
//            i_arm                 - start a new capture (IDLE/DONE only)
//            i_trig_mode           - 0 opcode match, 1 pc match
//            i_trig_op, i_trig_pc  - trigger compare values
//            i_cap_valid           - instruction retired this cycle
//            i_cap_pc/op/reg1/reg2/result - retired instruction fields
//            i_rd_ready            - consumer accepts o_rd_* this cycle
//            o_rd_valid            - o_rd_* hold a valid entry
//            o_rd_pc/op/reg1/reg2/result  - oldest held entry
//            o_state               - IDLE=0 ARMED=1 POST=2 DONE=3
//            o_count               - entries held (0..DEPTH)
//            o_wrapped             - ring overwrote an entry this capture
// Revision : 1.0 - initial release
// ============================================================================
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 8,
  parameter int OP_W      = 6,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_arm,
  input  logic                     i_trig_mode,
  input  logic [OP_W-1:0]          i_trig_op,
  input  logic [PC_W-1:0]          i_trig_pc,
  input  logic                     i_cap_valid,
  input  logic [PC_W-1:0]          i_cap_pc,
  input  logic [OP_W-1:0]          i_cap_op,
  input  logic [DATA_W-1:0]        i_cap_reg1,
  input  logic [DATA_W-1:0]        i_cap_reg2,
  input  logic [DATA_W-1:0]        i_cap_result,
  input  logic                     i_rd_ready,
  output logic                     o_rd_valid,
  output logic [PC_W-1:0]          o_rd_pc,
  output logic [OP_W-1:0]          o_rd_op,
  output logic [DATA_W-1:0]        o_rd_reg1,
  output logic [DATA_W-1:0]        o_rd_reg2,
  output logic [DATA_W-1:0]        o_rd_result,
  output logic [1:0]               o_state,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_wrapped
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int EW    = entry_w(PC_W, OP_W, DATA_W);

  localparam logic [CNT_W-1:0] c_full      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [AW-1:0]    c_post_last = AW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);

  state_t            r_state,    w_state_nx;
  logic [AW-1:0]     r_wr_ptr,   w_wr_ptr_nx;
  logic [AW-1:0]     r_rd_ptr,   w_rd_ptr_nx;
  logic [CNT_W-1:0]  r_count,    w_count_nx;
  logic [AW-1:0]     r_post_cnt, w_post_nx;
  logic              r_wrapped,  w_wrapped_nx;

  logic              w_we;
  logic              w_trig_hit;
  logic [AW-1:0]     w_wr_inc;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [AW-1:0]     w_rd_start;
  logic [EW-1:0]     w_wdata;
  logic [EW-1:0]     w_rdata;

  assign w_trig_hit = i_cap_valid &
                      ((i_trig_mode == TRIG_PC) ? (i_cap_pc == i_trig_pc)
                                                : (i_cap_op == i_trig_op));

  // DEPTH is a power of two, so the pointer wraps by natural overflow.
  assign w_wr_inc  = r_wr_ptr + 1'b1;
  assign w_cnt_inc = (r_count == c_full) ? r_count : r_count + 1'b1;

  // Oldest entry once the final write of the window lands. When the ring is
  // full the count's low bits are zero, so this is the slot about to be
  // overwritten next, i.e. the oldest survivor.
  assign w_rd_start = w_wr_inc - w_cnt_inc[AW-1:0];

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_post_cnt <= '0;
      r_wrapped  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_wr_ptr   <= w_wr_ptr_nx;
      r_rd_ptr   <= w_rd_ptr_nx;
      r_count    <= w_count_nx;
      r_post_cnt <= w_post_nx;
      r_wrapped  <= w_wrapped_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx   = r_state;
    w_wr_ptr_nx  = r_wr_ptr;
    w_rd_ptr_nx  = r_rd_ptr;
    w_count_nx   = r_count;
    w_post_nx    = r_post_cnt;
    w_wrapped_nx = r_wrapped;
    w_we         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_arm) begin
          w_state_nx   = S_ARMED;
          w_wr_ptr_nx  = '0;
          w_rd_ptr_nx  = '0;
          w_count_nx   = '0;
          w_post_nx    = '0;
          w_wrapped_nx = 1'b0;
        end
      end

      S_ARMED: begin
        if (i_cap_valid) begin
          w_we        = 1'b1;
          w_wr_ptr_nx = w_wr_inc;
          w_count_nx  = w_cnt_inc;
          w_post_nx   = '0;
          if (r_count == c_full) begin
            w_wrapped_nx = 1'b1;
          end
          if (w_trig_hit) begin
            if (POST_TRIG == 0) begin
              w_state_nx  = S_DONE;
              w_rd_ptr_nx = w_rd_start;
            end else begin
              w_state_nx  = S_POST;
            end
          end
        end
      end

      S_POST: begin
        if (i_cap_valid) begin
          w_we        = 1'b1;
          w_wr_ptr_nx = w_wr_inc;
          w_count_nx  = w_cnt_inc;
          w_post_nx   = r_post_cnt + 1'b1;
          if (r_count == c_full) begin
            w_wrapped_nx = 1'b1;
          end
          if (r_post_cnt == c_post_last) begin
            w_state_nx  = S_DONE;
            w_rd_ptr_nx = w_rd_start;
          end
        end
      end

      S_DONE: begin
        // A re-arm discards whatever is still waiting to be drained.
        if (i_arm) begin
          w_state_nx   = S_ARMED;
          w_wr_ptr_nx  = '0;
          w_rd_ptr_nx  = '0;
          w_count_nx   = '0;
          w_post_nx    = '0;
          w_wrapped_nx = 1'b0;
        end else if (r_count == '0) begin
          w_state_nx = S_IDLE;
        end else if (i_rd_ready) begin
          w_rd_ptr_nx = r_rd_ptr + 1'b1;
          w_count_nx  = r_count - 1'b1;
          if (r_count == c_one) begin
            w_state_nx = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage and field pack/unpack
  // --------------------------------------------------------------------------
  assign w_wdata = {i_cap_pc, i_cap_op, i_cap_reg1, i_cap_reg2, i_cap_result};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign {o_rd_pc, o_rd_op, o_rd_reg1, o_rd_reg2, o_rd_result} = w_rdata;

  assign o_rd_valid = (r_state == S_DONE) && (r_count != '0);
  assign o_state    = r_state;
  assign o_count    = r_count;
  assign o_wrapped  = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_capture_buffer
// Purpose  : Self-checking bench for trace_capture_buffer (DEPTH=8,
//            POST_TRIG=2). Directed scenarios followed by randomized traffic,
//            all compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_capture_buffer;

  localparam int DATA_W    = 32;
  localparam int PC_W      = 8;
  localparam int OP_W      = 6;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              arm;
  logic              trig_mode;
  logic [OP_W-1:0]   trig_op;
  logic [PC_W-1:0]   trig_pc;
  logic              cap_valid;
  logic [PC_W-1:0]   cap_pc;
  logic [OP_W-1:0]   cap_op;
  logic [DATA_W-1:0] cap_reg1, cap_reg2, cap_result;
  logic              rd_ready;
  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [OP_W-1:0]   rd_op;
  logic [DATA_W-1:0] rd_reg1, rd_reg2, rd_result;
  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic              wrapped;

  trace_capture_buffer #(
    .DATA_W(DATA_W), .PC_W(PC_W), .OP_W(OP_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_arm        (arm),
    .i_trig_mode  (trig_mode),
    .i_trig_op    (trig_op),
    .i_trig_pc    (trig_pc),
    .i_cap_valid  (cap_valid),
    .i_cap_pc     (cap_pc),
    .i_cap_op     (cap_op),
    .i_cap_reg1   (cap_reg1),
    .i_cap_reg2   (cap_reg2),
    .i_cap_result (cap_result),
    .i_rd_ready   (rd_ready),
    .o_rd_valid   (rd_valid),
    .o_rd_pc      (rd_pc),
    .o_rd_op      (rd_op),
    .o_rd_reg1    (rd_reg1),
    .o_rd_reg2    (rd_reg2),
    .o_rd_result  (rd_result),
    .o_state      (state),
    .o_count      (count),
    .o_wrapped    (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] res;
  } ent_t;

  ent_t m_q[$];      // entries held, oldest at index 0
  int   m_phase;     // 0 idle, 1 armed, 2 post-trigger, 3 done
  bit   m_wrapped;
  int   m_post_left;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_push();
    ent_t e;
    e.pc = cap_pc; e.op = cap_op; e.r1 = cap_reg1; e.r2 = cap_reg2; e.res = cap_result;
    m_q.push_back(e);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_wrapped = 1'b1;
    end
  endtask

  task automatic m_clear();
    m_q.delete();
    m_wrapped = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs applied to the DUT.
  task automatic model_update();
    bit hit;
    hit = trig_mode ? (cap_pc == trig_pc) : (cap_op == trig_op);
    if (!rst_n) begin
      m_phase = 0;
      m_clear();
      m_post_left = 0;
    end else begin
      case (m_phase)
        0: if (arm) begin m_phase = 1; m_clear(); end
        1: if (cap_valid) begin
             m_push();
             if (hit) begin
               if (POST_TRIG == 0) m_phase = 3;
               else begin m_post_left = POST_TRIG; m_phase = 2; end
             end
           end
        2: if (cap_valid) begin
             m_push();
             m_post_left--;
             if (m_post_left == 0) m_phase = 3;
           end
        default: begin
          if (arm) begin
            m_phase = 1;
            m_clear();
          end else if (rd_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = (m_phase == 3) && (m_q.size() > 0);
    chk("state",    64'(state),    64'(m_phase));
    chk("count",    64'(count),    64'(m_q.size()));
    chk("wrapped",  64'(wrapped),  64'(m_wrapped));
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    if (ev) begin
      chk("rd_pc",     64'(rd_pc),     64'(m_q[0].pc));
      chk("rd_op",     64'(rd_op),     64'(m_q[0].op));
      chk("rd_reg1",   64'(rd_reg1),   64'(m_q[0].r1));
      chk("rd_reg2",   64'(rd_reg2),   64'(m_q[0].r2));
      chk("rd_result", 64'(rd_result), 64'(m_q[0].res));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic feed(input int pc, input int op);
    cap_valid  = 1'b1;
    cap_pc     = PC_W'(pc);
    cap_op     = OP_W'(op);
    cap_reg1   = $urandom;
    cap_reg2   = $urandom;
    cap_result = $urandom;
    tick();
    cap_valid  = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 4 * DEPTH && m_phase != 0; k++) tick();
    chk("drain_idle", 64'(state), 64'(0));
    rd_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_phase = 0; m_post_left = 0; m_wrapped = 1'b0;
    rst_n = 1'b0; arm = 1'b1; trig_mode = 1'b0; trig_op = 6'b000110; trig_pc = '0;
    cap_valid = 1'b0; cap_pc = '0; cap_op = '0; cap_reg1 = '0; cap_reg2 = '0;
    cap_result = '0; rd_ready = 1'b0;

    // 1: reset with arm asserted
    tick(); tick();
    chk("t1_state",   64'(state),    64'(0));
    chk("t1_count",   64'(count),    64'(0));
    chk("t1_rdvalid", 64'(rd_valid), 64'(0));
    chk("t1_wrapped", 64'(wrapped),  64'(0));
    rst_n = 1'b1; arm = 1'b0;
    tick();
    chk("t1_noarm", 64'(state), 64'(0));

    // 2: opcode trigger at pc 3, six entries
    do_arm();
    chk("t2_armed", 64'(state), 64'(1));
    for (int i = 0; i < 6; i++) feed(i, (i == 3) ? 6 : i + 16);
    chk("t2_state",   64'(state),   64'(3));
    chk("t2_count",   64'(count),   64'(6));
    chk("t2_wrapped", 64'(wrapped), 64'(0));
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t2_rd_pc", 64'(rd_pc), 64'(i));
      tick();
    end
    chk("t2_rdvalid_end", 64'(rd_valid), 64'(0));
    chk("t2_idle",        64'(state),    64'(0));
    rd_ready = 1'b0;

    // 3: wrap, trigger at pc 9
    do_arm();
    for (int i = 0; i < 12; i++) feed(i, (i == 9) ? 6 : i + 16);
    chk("t3_state",   64'(state),   64'(3));
    chk("t3_count",   64'(count),   64'(8));
    chk("t3_wrapped", 64'(wrapped), 64'(1));

    // 4: back-pressure holds the head entry
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_pc",    64'(rd_pc), 64'(4));
      chk("t4_hold_count", 64'(count), 64'(8));
    end
    rd_ready = 1'b1;
    for (int i = 4; i < 12; i++) begin
      chk("t3_rd_pc", 64'(rd_pc), 64'(i));
      tick();
    end
    chk("t3_idle", 64'(state), 64'(0));
    rd_ready = 1'b0;

    // 5: pc trigger needs cap_valid
    trig_mode = 1'b1; trig_pc = 8'd7;
    do_arm();
    cap_valid = 1'b0; cap_pc = 8'd7;
    tick(); tick();
    chk("t5_novalid", 64'(state), 64'(1));
    feed(3, 6);
    chk("t5_opignored", 64'(state), 64'(1));
    feed(7, 0);
    chk("t5_post", 64'(state), 64'(2));
    feed(8, 0); feed(9, 0);
    chk("t5_done",  64'(state), 64'(3));
    chk("t5_count", 64'(count), 64'(4));
    drain();

    // 6: reset during POST, then clean restart
    do_arm();
    feed(7, 0);
    chk("t6_post", 64'(state), 64'(2));
    rst_n = 1'b0;
    tick();
    chk("t6_state", 64'(state), 64'(0));
    chk("t6_count", 64'(count), 64'(0));
    rst_n = 1'b1;
    do_arm();
    chk("t6_rearm",  64'(state), 64'(1));
    chk("t6_count0", 64'(count), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      arm        = ($urandom_range(0, 24) == 0);
      trig_mode  = $urandom_range(0, 1);
      trig_op    = OP_W'($urandom_range(0, 7));
      trig_pc    = PC_W'($urandom_range(0, 15));
      cap_valid  = ($urandom_range(0, 3) != 0);
      cap_pc     = PC_W'($urandom_range(0, 15));
      cap_op     = OP_W'($urandom_range(0, 15));
      cap_reg1   = $urandom;
      cap_reg2   = $urandom;
      cap_result = $urandom;
      rd_ready   = $urandom_range(0, 1);
      tick();
    end
    rst_n = 1'b1; arm = 1'b0; cap_valid = 1'b0;
    if (m_phase == 3) drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
